// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scan-code receiver.
//   ps2_state_t      frame FSM states (IDLE, DATA, PARITY, STOP)
//   PS2_PREFIX_EXT   E0 extended-key prefix
//   PS2_PREFIX_BREAK F0 key-release prefix
//   odd_parity_ok()  1 when data plus parity bit hold an odd number of ones
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

   localparam int PS2_DATA_BITS = 8;
   localparam int PS2_BIT_CNT_W = 3;

   function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                          input logic                     par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronizer, glitch filter and falling-edge strobe for one
// asynchronous pin.
//   clock27  in  system clock
//   reset_n  in  synchronous active-low reset (filtered level resets high = idle)
//   line     in  asynchronous pin
//   fall     out 1-cycle strobe when the filtered level goes 1 -> 0
// A new level is accepted only after FILTER_LEN consecutive synchronized
// samples that differ from the current level, so the strobe lags the pin
// edge by SYNC_STAGES + FILTER_LEN cycles.
module ps2_line_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 8
) (
   input  logic clock27,
   input  logic reset_n,
   input  logic line,
   output logic fall
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   level_q;
   logic                   sync_line;

   assign sync_line = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock27) begin
      if (!reset_n) begin
         sync_q  <= '1;
         cnt_q   <= '0;
         level_q <= 1'b1;
         fall    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], line};
         fall   <= 1'b0;
         if (sync_line == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            // this is the FILTER_LEN-th differing sample: accept it
            level_q <= sync_line;
            cnt_q   <= '0;
            fall    <= level_q;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 keyboard receive front end. Deserializes 11-bit
// device-to-host frames, strips E0/F0 prefixes and presents one key event per
// scan code.
//   clock27      in   system clock (27 MHz)
//   reset_n      in   synchronous active-low reset
//   ps2_clk      in   PS/2 clock pin (asynchronous)
//   ps2_data     in   PS/2 data pin (asynchronous)
//   key_data     out  scan code of last event, prefixes removed
//   key_pressed  out  1 from make of key_data until its matching break
//   key_valid    out  1-cycle strobe for a new event
//   key_break    out  event is a release (held after the strobe)
//   key_ext      out  event had E0 prefix (held after the strobe)
//   frame_err    out  1-cycle strobe: frame dropped (start/stop/parity/timeout)
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad parity;
// otherwise the parity bit is captured but not checked.
//
// state  | meaning
// IDLE   | waiting for a start bit (data=0 on a ps2_clk fall)
// DATA   | shifting 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking stop bit (and parity), then back to IDLE
module ps2_scan_receiver
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 27000
) (
   input  logic       clock27,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key_data,
   output logic       key_pressed,
   output logic       key_valid,
   output logic       key_break,
   output logic       key_ext,
   output logic       frame_err
);

`ifdef PS2_PARITY_CHECK_EN
   localparam logic PARITY_CHECK = 1'b1;
`else
   localparam logic PARITY_CHECK = 1'b0;
`endif

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

   logic fe;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic data_s;

   ps2_state_t               state_q, state_d;
   logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
   logic [PS2_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic                     par_q, par_d;
   logic [TMR_W-1:0]         timer_q, timer_d;
   logic                     byte_rdy_q, byte_rdy_d;
   logic                     err_d;
   logic                     frame_ok;
   logic                     ext_pend_q, brk_pend_q;

   ps2_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_clk_filter (
      .clock27 (clock27),
      .reset_n (reset_n),
      .line    (ps2_clk),
      .fall    (fe)
   );

   // data only needs synchronizing: it is sampled on fe, long after it settled
   always_ff @(posedge clock27) begin
      if (!reset_n) data_sync_q <= '1;
      else          data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
   end
   assign data_s = data_sync_q[SYNC_STAGES-1];

   // in the STOP state par_q holds the captured parity bit
   assign frame_ok = data_s & (odd_parity_ok(shift_q, par_q) | ~PARITY_CHECK);

   always_ff @(posedge clock27) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         par_q      <= 1'b0;
         timer_q    <= TMR_LOAD;
         byte_rdy_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         par_q      <= par_d;
         timer_q    <= timer_d;
         byte_rdy_q <= byte_rdy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      par_d      = par_q;
      timer_d    = timer_q;
      byte_rdy_d = 1'b0;
      err_d      = 1'b0;

      // down-counter: reloaded on every fe and while idle, terminal count 0
      if (state_q == IDLE || fe)    timer_d = TMR_LOAD;
      else if (timer_q != '0)       timer_d = timer_q - TMR_W'(1);

      if (fe) begin
         unique case (state_q)
            IDLE: begin
               if (!data_s) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
            DATA: begin
               shift_d = {data_s, shift_q[PS2_DATA_BITS-1:1]};
               if (bit_cnt_q == PS2_BIT_CNT_W'(PS2_DATA_BITS - 1)) state_d = PARITY;
               else bit_cnt_d = bit_cnt_q + PS2_BIT_CNT_W'(1);
            end
            PARITY: begin
               par_d   = data_s;
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (frame_ok) byte_rdy_d = 1'b1;
               else          err_d      = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && timer_q == '0) begin
         // an fe in the same cycle takes the branch above instead
         state_d = IDLE;
         err_d   = 1'b1;
      end
   end

   // Byte decode and output registers. byte_rdy_q only occurs in IDLE, so it
   // never coincides with err_d.
   always_ff @(posedge clock27) begin
      if (!reset_n) begin
         key_data    <= '0;
         key_pressed <= 1'b0;
         key_valid   <= 1'b0;
         key_break   <= 1'b0;
         key_ext     <= 1'b0;
         frame_err   <= 1'b0;
         ext_pend_q  <= 1'b0;
         brk_pend_q  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         frame_err <= err_d;
         if (err_d) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
         end else if (byte_rdy_q) begin
            if (shift_q == PS2_PREFIX_EXT) begin
               ext_pend_q <= 1'b1;
            end else if (shift_q == PS2_PREFIX_BREAK) begin
               brk_pend_q <= 1'b1;
            end else begin
               key_valid  <= 1'b1;
               key_data   <= shift_q;
               key_break  <= brk_pend_q;
               key_ext    <= ext_pend_q;
               ext_pend_q <= 1'b0;
               brk_pend_q <= 1'b0;
               // a release only clears pressed when it names the last key
               if (!brk_pend_q)               key_pressed <= 1'b1;
               else if (shift_q == key_data)  key_pressed <= 1'b0;
            end
         end
      end
   end

endmodule
